mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles a memory state waits for MEM_READY before aborting.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 OPCODE  input  6  instruction register bits [31:26], valid from DECODE onward.
REQ-005 MEM_READY  input  1  memory completion strobe for the current read or write.
REQ-006 PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE, MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A  output  1 each  standard multicycle datapath controls.
REQ-007 ALU_SRC_B  output  2  00=reg B, 01=constant 4, 10=sign/zero-extended immediate, 11=extended immediate shifted left 2.
REQ-008 ALU_OP  output  2  00=add, 01=subtract, 10=funct-decoded, 11=logic op selected by OPCODE[0] (0=AND, 1=OR).
REQ-009 PC_SOURCE  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 EXT_SEL  output  1  immediate extender mode: 0=sign-extend, 1=zero-extend.
REQ-011 ILLEGAL  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-012 MEM_ERR  output  1  one-cycle pulse when a memory state times out.
REQ-013 STATE  output  4  current state encoding, for debug.

Function
REQ-014 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB.
REQ-015 All control outputs SHALL be Moore (decoded from state only), except ALU_OP and EXT_SEL in I_EXEC, which also decode OPCODE.
REQ-016 FETCH: MEM_READ=1, I_OR_D=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=00, PC_SOURCE=00; state held while MEM_READY=0; on MEM_READY=1, IR_WRITE=1 and PC_WRITE=1 in that same cycle, next DECODE.
REQ-017 DECODE: ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=00, EXT_SEL=0; next by OPCODE: 000000->R_EXEC; 100011 or 101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP; 001000, 001100, 001101->I_EXEC; any other->FETCH with ILLEGAL=1.
REQ-018 MEM_ADDR: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00, EXT_SEL=0; next MEM_RD if OPCODE=100011, else MEM_WR.
REQ-019 MEM_RD: MEM_READ=1, I_OR_D=1; held until MEM_READY, then MEM_WB.
REQ-020 MEM_WB: REG_WRITE=1, MEM_TO_REG=1, REG_DST=0; next FETCH.
REQ-021 MEM_WR: MEM_WRITE=1, I_OR_D=1; held until MEM_READY, then FETCH.
REQ-022 R_EXEC: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10; next R_WB; R_WB: REG_WRITE=1, REG_DST=1, MEM_TO_REG=0; next FETCH.
REQ-023 BRANCH: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=01, PC_WRITE_COND=1, PC_SOURCE=01; next FETCH.
REQ-024 JUMP: PC_WRITE=1, PC_SOURCE=10; next FETCH.
REQ-025 I_EXEC: ALU_SRC_A=1, ALU_SRC_B=10; ADDI: ALU_OP=00, EXT_SEL=0; ANDI/ORI: ALU_OP=11, EXT_SEL=1; next I_WB; I_WB: REG_WRITE=1, REG_DST=0, MEM_TO_REG=0, EXT_SEL held from I_EXEC; next FETCH.
REQ-026 Signals not listed for a state SHALL be 0; memory state outputs SHALL stay constant across wait cycles.
REQ-027 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle MEM_READY=0 in those states; when it reaches MEM_TIMEOUT with MEM_READY=0, next state SHALL be FETCH with MEM_ERR=1 and no IR_WRITE, PC_WRITE or REG_WRITE.
REQ-028 MEM_READY=1 in the timeout cycle SHALL take priority: normal completion, no MEM_ERR.
REQ-029 The counter SHALL saturate and never wrap; its width SHALL be clog2(MEM_TIMEOUT+1).
REQ-030 Instruction latencies in cycles, zero-wait memory: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ 3, J 3.

Reset
REQ-031 RST=1 SHALL force state FETCH and the wait counter to 0 on the next edge, overriding any in-progress memory wait or write-back.
REQ-032 During and after reset all pulse outputs (ILLEGAL, MEM_ERR, PC_WRITE, IR_WRITE, REG_WRITE, MEM_WRITE) SHALL be 0 until FETCH sees MEM_READY; MEM_READ=1 from the first FETCH cycle.

Structure
REQ-033 A shared package mips_pkg SHALL hold the opcode constants, state encodings, and the ALU_SRC_B, ALU_OP and PC_SOURCE codes.
REQ-034 The control unit SHALL be one module with no sub-modules; the output decode SHALL be a single case on state.

Verification
REQ-035 LW (100011), MEM_READY always 1 -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; REG_WRITE=1 and MEM_TO_REG=1 on cycle 5 only.
REQ-036 ORI (001101) -> I_EXEC shows ALU_OP=11, EXT_SEL=1; I_WB shows REG_WRITE=1, REG_DST=0.
REQ-037 SW with MEM_READY low 3 cycles in MEM_WR -> MEM_WRITE=1 held 4 cycles, then FETCH, no MEM_ERR.
REQ-038 MEM_TIMEOUT=15, MEM_READY stuck 0 in FETCH -> MEM_ERR pulses once after 15 wait cycles; IR_WRITE never 1.
REQ-039 OPCODE 111111 in DECODE -> ILLEGAL=1 for one cycle, next state FETCH.
REQ-040 RST=1 while in MEM_RD waiting -> STATE=FETCH next cycle, REG_WRITE never asserted for the aborted load.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state
// encodings and the datapath mux/ALU select codes.
package mips_pkg;

    // Supported instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Controller state encodings (exposed on STATE for debug)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on MEM_READY and are covered by the timeout counter
    function automatic logic is_mem_wait(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory-wait timeout and illegal-opcode
// detection. Outputs are decoded from the current state; FETCH write
// strobes and the error pulses additionally qualify on MEM_READY/OPCODE.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OPCODE,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       PC_WRITE_COND,
    output logic       I_OR_D,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       MEM_TO_REG,
    output logic       REG_DST,
    output logic       REG_WRITE,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] ALU_OP,
    output logic [1:0] PC_SOURCE,
    output logic       EXT_SEL,
    output logic       ILLEGAL,
    output logic       MEM_ERR,
    output logic [3:0] STATE
);

    // A zero timeout still needs a one-bit counter to compare against
    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             ext_sel_q;
    logic             timeout;
    logic             legal_op;

    // Timeout only when the limit is reached and the memory is still not ready;
    // a ready strobe in that same cycle wins and completes normally.
    assign timeout = is_mem_wait(state_q) && !MEM_READY && (wait_cnt_q == CNT_LIMIT);

    assign legal_op = (OPCODE == OP_RTYPE) || (OPCODE == OP_LW)   || (OPCODE == OP_SW)   ||
                      (OPCODE == OP_BEQ)   || (OPCODE == OP_J)    || (OPCODE == OP_ADDI) ||
                      (OPCODE == OP_ANDI)  || (OPCODE == OP_ORI);

    assign STATE = state_q;

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MEM_READY)    state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
            end
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:               state_d = S_R_EXEC;
                    OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                    OP_BEQ:                 state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (MEM_READY)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (MEM_READY || timeout) state_d = S_FETCH;
            end
            S_R_EXEC: state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_I_EXEC: state_d = S_I_WB;
            S_I_WB:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Wait counter: restarts on every state entry (including the FETCH->FETCH
    // timeout retry) and saturates at the limit instead of wrapping.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) || timeout) begin
            wait_cnt_d = '0;
        end else if (is_mem_wait(state_q) && !MEM_READY && (wait_cnt_q != CNT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Output decode: one case on state, then reset suppresses all strobes
    always_comb begin
        PC_WRITE      = 1'b0;
        PC_WRITE_COND = 1'b0;
        I_OR_D        = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        IR_WRITE      = 1'b0;
        MEM_TO_REG    = 1'b0;
        REG_DST       = 1'b0;
        REG_WRITE     = 1'b0;
        ALU_SRC_A     = 1'b0;
        ALU_SRC_B     = SRCB_REG;
        ALU_OP        = ALUOP_ADD;
        PC_SOURCE     = PCSRC_ALU;
        EXT_SEL       = 1'b0;
        ILLEGAL       = 1'b0;
        MEM_ERR       = 1'b0;
        case (state_q)
            S_FETCH: begin
                MEM_READ  = 1'b1;
                ALU_SRC_B = SRCB_FOUR;
                IR_WRITE  = MEM_READY;
                PC_WRITE  = MEM_READY;
                MEM_ERR   = timeout;
            end
            S_DECODE: begin
                ALU_SRC_B = SRCB_IMM_SH;
                ILLEGAL   = !legal_op;
            end
            S_MEM_ADDR: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = SRCB_IMM;
            end
            S_MEM_RD: begin
                MEM_READ = 1'b1;
                I_OR_D   = 1'b1;
                MEM_ERR  = timeout;
            end
            S_MEM_WB: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = 1'b1;
            end
            S_MEM_WR: begin
                MEM_WRITE = 1'b1;
                I_OR_D    = 1'b1;
                MEM_ERR   = timeout;
            end
            S_R_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_OP    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                REG_WRITE = 1'b1;
                REG_DST   = 1'b1;
            end
            S_BRANCH: begin
                ALU_SRC_A     = 1'b1;
                ALU_OP        = ALUOP_SUB;
                PC_WRITE_COND = 1'b1;
                PC_SOURCE     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PC_WRITE  = 1'b1;
                PC_SOURCE = PCSRC_JUMP;
            end
            S_I_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = SRCB_IMM;
                if ((OPCODE == OP_ANDI) || (OPCODE == OP_ORI)) begin
                    ALU_OP  = ALUOP_LOGIC;
                    EXT_SEL = 1'b1;
                end
            end
            S_I_WB: begin
                REG_WRITE = 1'b1;
                EXT_SEL   = ext_sel_q;
            end
            default: ;
        endcase
        if (RST) begin
            PC_WRITE  = 1'b0;
            IR_WRITE  = 1'b0;
            REG_WRITE = 1'b0;
            MEM_WRITE = 1'b0;
            ILLEGAL   = 1'b0;
            MEM_ERR   = 1'b0;
        end
    end

    // State, wait counter and extender-mode hold for the I-type write-back
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            ext_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == S_I_EXEC) ext_sel_q <= EXT_SEL;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench for mips_mc_control. The reference model
// treats each instruction as a plan of phases built at decode time and
// walks it, with memory phases stretched by a wait/timeout rule.
module tb_mips_mc_control;
    import mips_pkg::*;

    localparam int TMO = 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] OPCODE;
    logic       MEM_READY;
    logic       PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE;
    logic       MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, EXT_SEL, ILLEGAL, MEM_ERR;
    logic [1:0] ALU_SRC_B, ALU_OP, PC_SOURCE;
    logic [3:0] STATE;

    mips_mc_control #(.MEM_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND), .I_OR_D(I_OR_D),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
        .MEM_TO_REG(MEM_TO_REG), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
        .PC_SOURCE(PC_SOURCE), .EXT_SEL(EXT_SEL), .ILLEGAL(ILLEGAL),
        .MEM_ERR(MEM_ERR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ext, ill, merr;
    } ctrl_t;

    int n_checks = 0;
    int n_errors = 0;
    int rw_seen, m2r_seen, mwr_seen, irw_seen, ill_seen, merr_seen;

    // Reference model state
    logic [3:0] m_state;
    int         m_wait;
    logic       m_ext;
    logic [3:0] plan[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_supported(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000, 6'b001100, 6'b001101};
    endfunction

    function automatic bit waits_on_mem(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // What each phase of the instruction should present to the datapath
    function automatic ctrl_t expected(input logic [5:0] op, input logic rdy, input logic rst);
        ctrl_t c;
        bit    tmo;
        c   = '0;
        tmo = waits_on_mem(m_state) && !rdy && (m_wait == TMO);
        case (m_state)
            S_FETCH:    begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; c.merr = tmo; end
            S_DECODE:   begin c.srcb = 2'b11; c.ill = !is_supported(op); end
            S_MEM_ADDR: begin c.srca = 1; c.srcb = 2'b10; end
            S_MEM_RD:   begin c.mrd = 1; c.iord = 1; c.merr = tmo; end
            S_MEM_WB:   begin c.rw = 1; c.m2r = 1; end
            S_MEM_WR:   begin c.mwr = 1; c.iord = 1; c.merr = tmo; end
            S_R_EXEC:   begin c.srca = 1; c.aluop = 2'b10; end
            S_R_WB:     begin c.rw = 1; c.rdst = 1; end
            S_BRANCH:   begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            S_JUMP:     begin c.pcw = 1; c.pcsrc = 2'b10; end
            S_I_EXEC: begin
                c.srca = 1; c.srcb = 2'b10;
                if (op != 6'b001000) begin c.aluop = 2'b11; c.ext = 1; end
            end
            S_I_WB:     begin c.rw = 1; c.ext = m_ext; end
            default: ;
        endcase
        if (rst) begin
            c.pcw = 0; c.irw = 0; c.rw = 0; c.mwr = 0; c.ill = 0; c.merr = 0;
        end
        return c;
    endfunction

    function automatic logic [3:0] next_phase();
        if (plan.size() != 0) return plan.pop_front();
        return S_FETCH;
    endfunction

    // Advance the model by one clock
    task automatic model_step(input logic [5:0] op, input logic rdy, input logic rst);
        logic [3:0] nxt;
        if (rst) begin
            m_state = S_FETCH; m_wait = 0; plan.delete();
            return;
        end
        nxt = m_state;
        if (waits_on_mem(m_state)) begin
            if (rdy) begin
                nxt = (m_state == S_FETCH) ? S_DECODE : next_phase();
            end else if (m_wait == TMO) begin
                plan.delete();
                nxt    = S_FETCH;
                m_wait = -1;          // forces a restart even though state is unchanged
            end else begin
                m_wait++;
            end
        end else if (m_state == S_DECODE) begin
            plan.delete();
            case (op)
                6'b100011: plan = '{S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
                6'b101011: plan = '{S_MEM_ADDR, S_MEM_WR};
                6'b000000: plan = '{S_R_EXEC, S_R_WB};
                6'b000100: plan = '{S_BRANCH};
                6'b000010: plan = '{S_JUMP};
                6'b001000, 6'b001100, 6'b001101: plan = '{S_I_EXEC, S_I_WB};
                default: ;
            endcase
            nxt = next_phase();
        end else begin
            if (m_state == S_I_EXEC) m_ext = (op != 6'b001000);
            nxt = next_phase();
        end
        if (nxt != m_state || m_wait < 0) m_wait = 0;
        m_state = nxt;
    endtask

    // Drive one cycle, compare against the model, then advance the model
    task automatic run_cycle(input logic [5:0] op, input logic rdy, input logic rst);
        ctrl_t obs, exp;
        @(negedge CLK);
        OPCODE = op; MEM_READY = rdy; RST = rst;
        #1;
        exp = expected(op, rdy, rst);
        obs = {PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE,
               MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ALU_SRC_B, ALU_OP,
               PC_SOURCE, EXT_SEL, ILLEGAL, MEM_ERR};
        check_eq("state", {28'b0, STATE}, {28'b0, m_state});
        check_eq("ctrl", {13'b0, obs}, {13'b0, exp});
        rw_seen   += int'(REG_WRITE);
        m2r_seen  += int'(MEM_TO_REG);
        mwr_seen  += int'(MEM_WRITE);
        irw_seen  += int'(IR_WRITE);
        ill_seen  += int'(ILLEGAL);
        merr_seen += int'(MEM_ERR);
        model_step(op, rdy, rst);
    endtask

    task automatic clear_seen();
        rw_seen = 0; m2r_seen = 0; mwr_seen = 0; irw_seen = 0; ill_seen = 0; merr_seen = 0;
    endtask

    logic [5:0] op_table[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h3F, 6'h11};
    int         stall_table[11] = '{0, 0, 0, 0, 1, 2, 3, 14, 15, 16, 25};

    initial begin
        logic [5:0] cur_op;
        int         stall;
        bit         armed;
        logic       rdy, rst;

        RST = 1'b1; OPCODE = 6'h00; MEM_READY = 1'b0;
        m_state = S_FETCH; m_wait = 0; m_ext = 1'b0;
        clear_seen();
        repeat (2) @(posedge CLK);

        // LW with zero-wait memory: five phases, one register write at the end
        clear_seen();
        repeat (5) run_cycle(OP_LW, 1'b1, 1'b0);
        check_eq("lw_regwrite_cnt", rw_seen, 1);
        check_eq("lw_memtoreg_cnt", m2r_seen, 1);

        // ORI: logic ALU op with zero-extension, held into write-back
        repeat (4) run_cycle(OP_ORI, 1'b1, 1'b0);

        // SW with three not-ready cycles in MEM_WR
        clear_seen();
        repeat (3) run_cycle(OP_SW, 1'b1, 1'b0);
        repeat (3) run_cycle(OP_SW, 1'b0, 1'b0);
        run_cycle(OP_SW, 1'b1, 1'b0);
        check_eq("sw_memwrite_cnt", mwr_seen, 4);
        check_eq("sw_no_memerr", merr_seen, 0);

        // FETCH never gets ready: one timeout pulse after 15 wait cycles
        clear_seen();
        repeat (16) run_cycle(OP_LW, 1'b0, 1'b0);
        check_eq("fetch_tmo_memerr_cnt", merr_seen, 1);
        check_eq("fetch_tmo_no_irwrite", irw_seen, 0);

        // Unsupported opcode
        clear_seen();
        repeat (2) run_cycle(6'h3F, 1'b1, 1'b0);
        check_eq("illegal_cnt", ill_seen, 1);

        // Reset while a load is stalled in MEM_RD
        clear_seen();
        repeat (3) run_cycle(OP_LW, 1'b1, 1'b0);
        repeat (2) run_cycle(OP_LW, 1'b0, 1'b0);
        run_cycle(OP_LW, 1'b0, 1'b1);
        repeat (2) run_cycle(OP_LW, 1'b0, 1'b0);
        check_eq("abort_no_regwrite", rw_seen, 0);

        // Randomized instruction stream with random memory stalls and resets
        armed  = 0;
        stall  = 0;
        cur_op = OP_RTYPE;
        for (int n = 0; n < 4000; n++) begin
            if (m_state == S_FETCH) cur_op = op_table[$urandom_range(0, 9)];
            rst = ($urandom_range(0, 199) == 0);
            if (waits_on_mem(m_state)) begin
                if (!armed) begin
                    stall = stall_table[$urandom_range(0, 10)];
                    armed = 1;
                end
                rdy = (stall == 0);
                if (stall > 0) stall--;
            end else begin
                rdy   = 1'($urandom_range(0, 1));
                armed = 0;
            end
            run_cycle(cur_op, rdy, rst);
            if (rdy || m_wait == 0) armed = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
